// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

  // Hazard controller states
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_FREEZE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } hz_state_t;

  // Default register-address width (32 architectural registers)
  localparam int REG_AW_DEF = 5;

  // HALT opcode, also decoded by the ID-stage decoder
  localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational hazard comparator: returns the number of stall cycles (0..2)
// the instruction in ID needs, given the producers in EX and MEM.
module hazard_cmp
  import mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_use_rs,
  input  logic              i_use_rt,
  input  logic              i_branch,
  input  logic              i_ex_wreg,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_memread,
  input  logic [REG_AW-1:0] i_mem_rd,
  output logic [1:0]        o_need
);

  logic w_ex_match;
  logic w_mem_match;

  // A producer matches when it writes a non-zero register that ID really reads
  function automatic logic src_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              use_rs,
                                     input logic              use_rt);
    return (rd != '0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
  endfunction

  // Classify the hazard into a required stall length
  always_comb begin
    w_ex_match  = src_match(i_ex_rd, i_rs, i_rt, i_use_rs, i_use_rt);
    w_mem_match = src_match(i_mem_rd, i_rs, i_rt, i_use_rs, i_use_rt);
    o_need      = 2'd0;
    if (i_branch && i_ex_memread && w_ex_match) begin
      o_need = 2'd2;
    end else if ((i_ex_memread && w_ex_match) ||
                 (i_branch && i_ex_wreg && w_ex_match) ||
                 (i_branch && i_mem_memread && w_mem_match)) begin
      o_need = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Sequential hazard controller for the 5-stage pipeline: load-use and branch
// operand stalls, taken-branch flush, memory-wait freeze, halt drain, debug
// gating and a saturating stall statistics counter.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter int STAT_W       = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic              i_id_branch,
  input  logic              i_id_taken,
  input  logic              i_id_halt,
  input  logic              i_ex_wreg,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_memread,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_busy,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_id_ex_bubble,
  output logic              o_if_id_flush,
  output logic              o_halted,
  output logic [STAT_W-1:0] o_stall_count
);

  // Drain counter only has to hold DRAIN_CYCLES-1
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_t         r_state;
  hz_state_t         r_ret;
  logic [1:0]        r_cnt;
  logic [DW-1:0]     r_dcnt;
  logic [STAT_W-1:0] r_stat;

  hz_state_t         w_eff;
  hz_state_t         w_next_state;
  hz_state_t         w_next_ret;
  logic [1:0]        w_next_cnt;
  logic [DW-1:0]     w_next_dcnt;
  logic              w_count;
  logic [1:0]        w_need;

  // Saturating increment for the statistics counter
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .i_rs          (i_id_rs),
    .i_rt          (i_id_rt),
    .i_use_rs      (i_id_use_rs),
    .i_use_rt      (i_id_use_rt),
    .i_branch      (i_id_branch),
    .i_ex_wreg     (i_ex_wreg),
    .i_ex_memread  (i_ex_memread),
    .i_ex_rd       (i_ex_rd),
    .i_mem_memread (i_mem_memread),
    .i_mem_rd      (i_mem_rd),
    .o_need        (w_need)
  );

  // Effective state: a freeze transparently resumes its preserved state
  always_comb begin
    w_eff = (r_state == ST_FREEZE) ? r_ret : r_state;
  end

  // Next-state and stage-enable decode; everything holds unless enabled
  always_comb begin
    w_next_state   = r_state;
    w_next_ret     = r_ret;
    w_next_cnt     = r_cnt;
    w_next_dcnt    = r_dcnt;
    w_count        = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_halted       = (r_state == ST_HALTED);
    if (i_reset_n && i_enable && (r_state != ST_HALTED)) begin
      if (i_mem_busy) begin
        // Memory wait: freeze everything, remember where to come back to
        w_next_state = ST_FREEZE;
        w_next_ret   = w_eff;
        w_count      = 1'b1;
      end else begin
        w_next_state = w_eff;
        case (w_eff)
          ST_DRAIN: begin
            o_ex_mem_en    = 1'b1;
            o_mem_wb_en    = 1'b1;
            o_id_ex_bubble = 1'b1;
            if (r_dcnt <= DW'(1)) begin
              w_next_state = ST_HALTED;
            end else begin
              w_next_dcnt = r_dcnt - DW'(1);
            end
          end
          ST_STALL: begin
            o_ex_mem_en    = 1'b1;
            o_mem_wb_en    = 1'b1;
            o_id_ex_bubble = 1'b1;
            w_count        = 1'b1;
            if (r_cnt <= 2'd1) begin
              w_next_cnt   = 2'd0;
              w_next_state = ST_RUN;
            end else begin
              w_next_cnt = r_cnt - 2'd1;
            end
          end
          default: begin
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
            if (w_need != 2'd0) begin
              o_id_ex_bubble = 1'b1;
              w_count        = 1'b1;
              w_next_cnt     = w_need - 2'd1;
              w_next_state   = (w_need == 2'd2) ? ST_STALL : ST_RUN;
            end else if (i_id_halt) begin
              // The halt cycle itself is the first of the drain bubbles
              o_id_ex_bubble = 1'b1;
              w_next_dcnt    = DW'(DRAIN_CYCLES - 1);
              w_next_state   = (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
            end else begin
              o_pc_en       = 1'b1;
              o_if_id_en    = 1'b1;
              o_if_id_flush = i_id_taken;
            end
          end
        endcase
      end
    end
  end

  // State, counters and statistics registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_cnt   <= 2'd0;
      r_dcnt  <= '0;
      r_stat  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ret   <= w_next_ret;
      r_cnt   <= w_next_cnt;
      r_dcnt  <= w_next_dcnt;
      if (w_count) begin
        r_stat <= sat_inc(r_stat);
      end
    end
  end

  assign o_stall_count = r_stat;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: default instance plus a 4-bit
// statistics instance sharing the same stimulus.
module tb_hazard_ctrl;

  logic       i_clock;
  logic       i_reset_n;
  logic       i_enable;
  logic [4:0] i_id_rs, i_id_rt, i_ex_rd, i_mem_rd;
  logic       i_id_use_rs, i_id_use_rt, i_id_branch, i_id_taken, i_id_halt;
  logic       i_ex_wreg, i_ex_memread, i_mem_memread, i_mem_busy;

  logic        pc_en, if_id_en, ex_mem_en, mem_wb_en, bubble, flush, halted;
  logic [31:0] stall_count;
  logic        s_pc_en, s_if_id_en, s_ex_mem_en, s_mem_wb_en, s_bubble, s_flush, s_halted;
  logic [3:0]  s_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view: {pc, if_id, ex_mem, mem_wb, bubble, flush, halted}
  wire [6:0] outs = {pc_en, if_id_en, ex_mem_en, mem_wb_en, bubble, flush, halted};

  localparam logic [6:0] O_ZERO  = 7'b0000000;
  localparam logic [6:0] O_RUN   = 7'b1111000;
  localparam logic [6:0] O_STALL = 7'b0011100;
  localparam logic [6:0] O_FLUSH = 7'b1111010;
  localparam logic [6:0] O_HALT  = 7'b0000001;

  hazard_ctrl dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_use_rs(i_id_use_rs),
    .i_id_use_rt(i_id_use_rt), .i_id_branch(i_id_branch), .i_id_taken(i_id_taken),
    .i_id_halt(i_id_halt), .i_ex_wreg(i_ex_wreg), .i_ex_memread(i_ex_memread),
    .i_ex_rd(i_ex_rd), .i_mem_memread(i_mem_memread), .i_mem_rd(i_mem_rd),
    .i_mem_busy(i_mem_busy), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en), .o_id_ex_bubble(bubble),
    .o_if_id_flush(flush), .o_halted(halted), .o_stall_count(stall_count)
  );

  hazard_ctrl #(.STAT_W(4)) dut_s (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_use_rs(i_id_use_rs),
    .i_id_use_rt(i_id_use_rt), .i_id_branch(i_id_branch), .i_id_taken(i_id_taken),
    .i_id_halt(i_id_halt), .i_ex_wreg(i_ex_wreg), .i_ex_memread(i_ex_memread),
    .i_ex_rd(i_ex_rd), .i_mem_memread(i_mem_memread), .i_mem_rd(i_mem_rd),
    .i_mem_busy(i_mem_busy), .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en),
    .o_ex_mem_en(s_ex_mem_en), .o_mem_wb_en(s_mem_wb_en), .o_id_ex_bubble(s_bubble),
    .o_if_id_flush(s_flush), .o_halted(s_halted), .o_stall_count(s_stall_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_id_rs = 5'd0; i_id_rt = 5'd0; i_id_use_rs = 1'b0; i_id_use_rt = 1'b0;
    i_id_branch = 1'b0; i_id_taken = 1'b0; i_id_halt = 1'b0;
    i_ex_wreg = 1'b0; i_ex_memread = 1'b0; i_ex_rd = 5'd0;
    i_mem_memread = 1'b0; i_mem_rd = 5'd0; i_mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [6:0] exp);
    #2;
    check(tag, {25'd0, outs}, {25'd0, exp});
  endtask

  // EX holds a load to rd, ID reads rs=rd
  task automatic load_use(input logic [4:0] rd, input logic br);
    idle();
    i_ex_memread = 1'b1; i_ex_wreg = 1'b1; i_ex_rd = rd;
    i_id_rs = rd; i_id_use_rs = 1'b1; i_id_branch = br;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    idle();
    load_use(5'd5, 1'b0);
    // Reset: outputs forced low even with a hazard present
    expect_o("reset_outs", O_ZERO);
    check("reset_count", stall_count, 32'd0);
    tick(); tick();
    i_reset_n = 1'b1;
    idle();
    expect_o("run_after_reset", O_RUN);
    check("count_after_reset", stall_count, 32'd0);
    tick();

    // Load-use: one bubble
    load_use(5'd5, 1'b0);
    expect_o("loaduse_stall", O_STALL);
    tick();
    idle(); i_mem_memread = 1'b1; i_mem_rd = 5'd5; i_id_rs = 5'd5; i_id_use_rs = 1'b1;
    expect_o("loaduse_release", O_RUN);
    check("loaduse_count", stall_count, 32'd1);
    tick();

    // Register 0 and unused operand never stall
    load_use(5'd0, 1'b0);
    expect_o("reg0_nostall", O_RUN);
    tick();
    idle(); i_ex_memread = 1'b1; i_ex_wreg = 1'b1; i_ex_rd = 5'd7; i_id_rt = 5'd7;
    expect_o("unused_rt_nostall", O_RUN);
    tick();

    // Branch after load in EX: two stall cycles then taken flush
    load_use(5'd3, 1'b1);
    i_id_taken = 1'b1;
    expect_o("brload_stall1", O_STALL);
    tick();
    idle(); i_id_branch = 1'b1; i_id_rs = 5'd3; i_id_use_rs = 1'b1;
    i_mem_memread = 1'b1; i_mem_rd = 5'd3; i_id_taken = 1'b1;
    expect_o("brload_stall2", O_STALL);
    tick();
    i_mem_memread = 1'b0; i_mem_rd = 5'd0;
    expect_o("brload_flush", O_FLUSH);
    check("brload_count", stall_count, 32'd3);
    tick();
    idle();
    expect_o("after_flush", O_RUN);
    tick();

    // Branch after ALU op: one stall, no flush while stalled
    idle(); i_id_branch = 1'b1; i_id_taken = 1'b1; i_id_rt = 5'd4; i_id_use_rt = 1'b1;
    i_ex_wreg = 1'b1; i_ex_rd = 5'd4;
    expect_o("bralu_stall_noflush", O_STALL);
    tick();
    // Branch after load in MEM: one stall
    idle(); i_id_branch = 1'b1; i_id_rs = 5'd6; i_id_use_rs = 1'b1;
    i_mem_memread = 1'b1; i_mem_rd = 5'd6;
    expect_o("brmemload_stall", O_STALL);
    tick();
    idle();
    expect_o("brmemload_release", O_RUN);
    check("branch_count", stall_count, 32'd5);
    tick();

    // Freeze for three cycles in the middle of a two-cycle stall
    load_use(5'd3, 1'b1);
    expect_o("frz_stall1", O_STALL);
    tick();
    idle(); i_mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_o("frz_freeze", O_ZERO);
      tick();
    end
    i_mem_busy = 1'b0;
    expect_o("frz_resume_stall", O_STALL);
    tick();
    expect_o("frz_release", O_RUN);
    check("frz_count", stall_count, 32'd10);
    tick();

    // Debug gating: nothing moves and nothing is counted
    load_use(5'd5, 1'b0);
    i_enable = 1'b0;
    expect_o("dis_outs", O_ZERO);
    tick(); tick();
    check("dis_count", stall_count, 32'd10);
    // Disable in the middle of a STALL, then step to finish it
    i_enable = 1'b1;
    load_use(5'd3, 1'b1);
    expect_o("step_stall1", O_STALL);
    tick();
    idle(); i_enable = 1'b0;
    expect_o("step_hold", O_ZERO);
    tick();
    i_enable = 1'b1;
    expect_o("step_resume", O_STALL);
    tick();
    expect_o("step_release", O_RUN);
    check("step_count", stall_count, 32'd12);
    check("sat_pre", {28'd0, s_stall_count}, 32'd12);
    tick();

    // Saturation: 20 more stall cycles
    load_use(5'd9, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    idle();
    #2;
    check("sat_wide_count", stall_count, 32'd32);
    check("sat_narrow_count", {28'd0, s_stall_count}, 32'd15);
    tick();

    // Halt: three bubble cycles then held halted
    idle(); i_id_halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_o("drain", O_HALT ^ O_HALT ^ O_STALL);
      tick();
    end
    expect_o("halted", O_HALT);
    tick();
    i_mem_busy = 1'b1;
    expect_o("halted_busy", O_HALT);
    check("halt_count", stall_count, 32'd32);
    check("halted_narrow", {31'd0, s_halted}, 32'd1);
    // Asynchronous reset leaves HALTED immediately
    #1 i_reset_n = 1'b0;
    #1;
    check("halt_reset_outs", {25'd0, outs}, 32'd0);
    check("halt_reset_count", stall_count, 32'd0);
    tick();
    i_reset_n = 1'b1;
    idle();
    expect_o("run_after_halt_reset", O_RUN);
    tick();

    // Reset in the middle of a drain
    load_use(5'd5, 1'b0);
    expect_o("pre_drain_stall", O_STALL);
    tick();
    idle(); i_id_halt = 1'b1;
    expect_o("drain2_a", O_STALL);
    tick();
    expect_o("drain2_b", O_STALL);
    check("drain2_count", stall_count, 32'd1);
    #1 i_reset_n = 1'b0;
    #1;
    check("drain_reset_outs", {25'd0, outs}, 32'd0);
    check("drain_reset_count", stall_count, 32'd0);
    tick();
    i_reset_n = 1'b1;
    idle();
    expect_o("run_after_drain_reset", O_RUN);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
